// File: rtl/l1dcache_server_if.sv
// Core-side request/response bundle for the L1 data cache.
// Requests are word-addressed; the response arrives exactly one cycle later.
interface l1dcache_core_if;
  logic        req_valid;
  logic        req_we;
  logic [29:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_mask;
  logic        resp_ack;
  logic [31:0] resp_data;

  modport Server (
    input  req_valid, req_we, req_addr, req_data, req_mask,
    output resp_ack, resp_data
  );

  modport Client (
    output req_valid, req_we, req_addr, req_data, req_mask,
    input  resp_ack, resp_data
  );
endinterface

// File: rtl/l1dcache_server.sv
// Direct-mapped, one-word-per-line, write-through/no-write-allocate L1 data cache.
// Load misses are refilled from backing memory; the core replays the load afterwards.
module l1dcache_server #(
  parameter int unsigned NUM_LINES = 64,
  parameter int unsigned IDX_W     = $clog2(NUM_LINES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  l1dcache_core_if.Server        cache,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_we,
  output logic [29:0]            mem_req_addr,
  output logic [31:0]            mem_req_data,
  output logic [3:0]             mem_req_mask,
  input  logic                   mem_resp_valid,
  input  logic [31:0]            mem_resp_data
);

  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    REFILL_REQ  = 2'd1,
    REFILL_WAIT = 2'd2
  } state_t;

  state_t               state;
  logic [29:0]          miss_addr;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES];

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;
  logic             hit;
  logic             load_go;
  logic             store_go;
  logic             store_merge;
  logic             fill_go;

  assign req_idx  = cache.req_addr[IDX_W-1:0];
  assign req_tag  = cache.req_addr[29:IDX_W];
  assign miss_idx = miss_addr[IDX_W-1:0];
  assign miss_tag = miss_addr[29:IDX_W];

  assign hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign load_go     = (state == IDLE) && cache.req_valid && !cache.req_we;
  assign store_go    = rst_n && (state == IDLE) && cache.req_valid && cache.req_we;
  assign store_merge = store_go && mem_req_ready && hit;
  assign fill_go     = (state == REFILL_WAIT) && mem_resp_valid;

  // Memory port: refill read owns it in REFILL_REQ, otherwise an IDLE store passes straight through.
  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    mem_req_mask  = '0;
    if (state == REFILL_REQ) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = miss_addr;
      mem_req_mask  = 4'b1111;
    end else if (store_go) begin
      mem_req_valid = 1'b1;
      mem_req_we    = 1'b1;
      mem_req_addr  = cache.req_addr;
      mem_req_data  = cache.req_data;
      mem_req_mask  = cache.req_mask;
    end
  end

  // Control FSM, valid bits and the registered core response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      miss_addr       <= '0;
      valid_q         <= '0;
      cache.resp_ack  <= 1'b0;
      cache.resp_data <= '0;
    end else begin
      cache.resp_ack  <= 1'b0;
      cache.resp_data <= '0;
      case (state)
        IDLE: begin
          if (load_go) begin
            if (hit) begin
              cache.resp_ack  <= 1'b1;
              cache.resp_data <= data_q[req_idx];
            end else begin
              miss_addr <= cache.req_addr;
              state     <= REFILL_REQ;
            end
          end else if (store_go) begin
            cache.resp_ack <= mem_req_ready;
          end
        end
        REFILL_REQ: begin
          if (mem_req_ready) begin
            state <= REFILL_WAIT;
          end
        end
        REFILL_WAIT: begin
          if (mem_resp_valid) begin
            valid_q[miss_idx] <= 1'b1;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (fill_go) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= mem_resp_data;
    end else if (store_merge) begin
      for (int b = 0; b < 4; b++) begin
        if (cache.req_mask[b]) begin
          data_q[req_idx][8*b +: 8] <= cache.req_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_l1dcache_server.sv
// Randomized bench for l1dcache_server against a line-table and backing-memory reference model.
module tb_l1dcache_server;

  localparam int unsigned LINES = 64;

  logic        clk;
  logic        rst_n;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [29:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_mask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  l1dcache_core_if cache_if();

  l1dcache_server #(.NUM_LINES(LINES)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cache          (cache_if),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_mask   (mem_req_mask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: what each cache line holds, the backing memory, and any outstanding refill.
  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];
  logic [31:0] m_data  [LINES];
  logic [31:0] mem     [logic [29:0]];
  int          refill_stage = 0;   // 0 none, 1 read not yet accepted, 2 read accepted awaiting data
  logic [29:0] refill_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [29:0] a);
    if (mem.exists(a)) return mem[a];
    return {2'b01, a} ^ 32'h3C5A_9617;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // One core/memory cycle: drive at negedge, check the memory port, predict, check the response after posedge.
  task automatic cycle(input logic rv, input logic we, input logic [29:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic rdy, input logic rsp);
    logic        exp_ack;
    logic [31:0] exp_data;
    bit          chk_data;
    bit          busy;
    bit          hit;
    int          idx;
    cache_if.req_valid = rv;
    cache_if.req_we    = we;
    cache_if.req_addr  = a;
    cache_if.req_data  = d;
    cache_if.req_mask  = m;
    mem_req_ready      = rdy;
    mem_resp_valid     = rsp;
    mem_resp_data      = (refill_stage == 2 && rsp) ? mem_rd(refill_addr) : $urandom();
    #1;
    if (refill_stage == 1) begin
      chk("rd_valid", 32'(mem_req_valid), 32'd1);
      chk("rd_we",    32'(mem_req_we),    32'd0);
      chk("rd_addr",  32'(mem_req_addr),  32'(refill_addr));
      chk("rd_mask",  32'(mem_req_mask),  32'hF);
    end else if (refill_stage == 0 && rv && we) begin
      chk("wr_valid", 32'(mem_req_valid), 32'd1);
      chk("wr_we",    32'(mem_req_we),    32'd1);
      chk("wr_addr",  32'(mem_req_addr),  32'(a));
      chk("wr_data",  mem_req_data,       d);
      chk("wr_mask",  32'(mem_req_mask),  32'(m));
    end else begin
      chk("mem_idle", 32'(mem_req_valid), 32'd0);
    end

    busy     = (refill_stage != 0);
    exp_ack  = 1'b0;
    exp_data = '0;
    chk_data = 1;
    if (refill_stage == 1 && rdy) begin
      refill_stage = 2;
    end else if (refill_stage == 2 && rsp) begin
      idx          = int'(refill_addr[5:0]);
      m_valid[idx] = 1;
      m_tag[idx]   = int'(refill_addr[29:6]);
      m_data[idx]  = mem_rd(refill_addr);
      refill_stage = 0;
    end
    if (rv && busy) begin
      chk_data = 0;
    end else if (rv) begin
      idx = int'(a[5:0]);
      hit = m_valid[idx] && (m_tag[idx] == int'(a[29:6]));
      if (!we) begin
        if (hit) begin
          exp_ack  = 1'b1;
          exp_data = m_data[idx];
        end else begin
          refill_stage = 1;
          refill_addr  = a;
        end
      end else begin
        exp_ack  = rdy;
        chk_data = 0;
        if (rdy) begin
          mem[a] = merge(mem_rd(a), d, m);
          if (hit) m_data[idx] = merge(m_data[idx], d, m);
        end
      end
    end
    @(posedge clk);
    #1;
    chk("resp_ack", 32'(cache_if.resp_ack), 32'(exp_ack));
    if (chk_data) chk("resp_data", cache_if.resp_data, exp_data);
    @(negedge clk);
  endtask

  task automatic load(input logic [29:0] a, input logic rdy, input logic rsp);
    cycle(1'b1, 1'b0, a, '0, '0, rdy, rsp);
  endtask

  task automatic idle(input logic rdy, input logic rsp);
    cycle(1'b0, 1'b0, '0, '0, '0, rdy, rsp);
  endtask

  // Asynchronous reset mid-run with a stray memory response while reset is held.
  task automatic do_reset();
    cache_if.req_valid = 1'b0;
    cache_if.req_we    = 1'b0;
    mem_req_ready      = 1'b0;
    mem_resp_valid     = 1'b0;
    rst_n              = 1'b0;
    #1;
    chk("rst_ack",  32'(cache_if.resp_ack),  32'd0);
    chk("rst_data", cache_if.resp_data,      32'd0);
    chk("rst_mreq", 32'(mem_req_valid),      32'd0);
    for (int i = 0; i < LINES; i++) m_valid[i] = 0;
    refill_stage = 0;
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_data  = $urandom();
    @(negedge clk);
    mem_resp_valid = 1'b0;
    rst_n          = 1'b1;
  endtask

  initial begin
    logic [29:0] a;
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_data[i]  = '0;
    end
    rst_n              = 1'b0;
    cache_if.req_valid = 1'b0;
    cache_if.req_we    = 1'b0;
    cache_if.req_addr  = '0;
    cache_if.req_data  = '0;
    cache_if.req_mask  = '0;
    mem_req_ready      = 1'b0;
    mem_resp_valid     = 1'b0;
    mem_resp_data      = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_ack",  32'(cache_if.resp_ack), 32'd0);
    chk("reset_data", cache_if.resp_data,     32'd0);
    chk("reset_mreq", 32'(mem_req_valid),     32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Miss, refill, replay hit.
    mem[30'h10] = 32'hDEADBEEF;
    load(30'h10, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b1);
    load(30'h10, 1'b0, 1'b0);
    chk("replay_const", cache_if.resp_data, 32'hDEADBEEF);

    // Byte-merge store on the cached line.
    cycle(1'b1, 1'b1, 30'h10, 32'h0000AA00, 4'b0010, 1'b1, 1'b0);
    load(30'h10, 1'b0, 1'b0);
    chk("merge_const", cache_if.resp_data, 32'hDEADAAEF);

    // Refused store, then retried; then a mask-0 store.
    cycle(1'b1, 1'b1, 30'h10, 32'h12345678, 4'b1111, 1'b0, 1'b0);
    load(30'h10, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 30'h10, 32'h12345678, 4'b1111, 1'b1, 1'b0);
    load(30'h10, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 30'h10, 32'hFFFFFFFF, 4'b0000, 1'b1, 1'b0);
    load(30'h10, 1'b0, 1'b0);

    // Conflict eviction at the same index.
    load(30'h50, 1'b1, 1'b0);
    idle(1'b0, 1'b1);
    load(30'h50, 1'b0, 1'b0);
    load(30'h10, 1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b1);

    // Loads every cycle across a 5-cycle refill, including the completion cycle.
    load(30'h20, 1'b0, 1'b0);
    load(30'h20, 1'b0, 1'b0);
    load(30'h20, 1'b1, 1'b0);
    load(30'h21, 1'b0, 1'b0);
    load(30'h20, 1'b0, 1'b0);
    load(30'h20, 1'b0, 1'b1);
    load(30'h20, 1'b0, 1'b0);

    // Reset while waiting for refill data abandons it.
    load(30'h33, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    do_reset();
    idle(1'b0, 1'b1);
    load(30'h10, 1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b1);

    // Randomized traffic over a few indices and tags to provoke hits, conflicts and stalls.
    for (int n = 0; n < 2000; n++) begin
      int unsigned ix;
      ix = ($urandom_range(0, 4) == 4) ? 63 : $urandom_range(0, 3);
      a  = 30'($urandom_range(0, 2) * LINES + ix);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, a, $urandom(),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            (refill_stage == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
